// File: rtl/clk_tick_gen_pkg.sv
// clk_tick_gen_pkg: shared constants for the tick/divided-clock generator
package clk_tick_gen_pkg;
    localparam int   DIV_MIN     = 1;
    localparam int   DIV_DEFAULT = 4;
    localparam logic CLKDIV_RST  = 1'b1;
endpackage

// File: rtl/clk_tick_gen_if.sv
// clk_tick_gen_if: control and status bundle of the tick generator
interface clk_tick_gen_if #(parameter int WIDTH = 16);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             pending;
    logic [WIDTH-1:0] div_cur;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             clk_div;
    modport master (output en, div_in, div_load, input pending, div_cur, cnt, tick, clk_div);
    modport slave  (input en, div_in, div_load, output pending, div_cur, cnt, tick, clk_div);
endinterface

// File: rtl/clk_tick_gen_cnt.sv
// clk_tick_cnt: enabled modulo-D phase counter with wrap detect and idle clear
module clk_tick_cnt
    import clk_tick_gen_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_cnt_next,
    output logic             o_wrap
);
    logic [WIDTH-1:0] r_cnt;
    assign o_wrap     = i_en && (r_cnt == i_div - WIDTH'(DIV_MIN));
    assign o_cnt_next = (o_wrap || i_clr) ? '0 : i_en ? r_cnt + WIDTH'(1) : r_cnt;
    assign o_cnt      = r_cnt;
    // phase register; the next value is shared with the top for clk_div
    always_ff @(posedge clk) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= o_cnt_next;
    end
endmodule

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: clock-enable tick and divided square wave with glitch-free divisor reload
module clk_tick_gen
    import clk_tick_gen_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    clk_tick_gen_if.slave   bus
);
    logic [WIDTH-1:0] r_div_cur, r_pend_val;
    logic [WIDTH-1:0] w_cnt, w_cnt_next, w_div_next, w_hi_len, w_div_in;
    logic             r_pending, r_tick, r_clk_div;
    logic             w_wrap, w_apply, w_apply_idle;
    assign w_div_in     = (bus.div_in == '0) ? WIDTH'(DIV_MIN) : bus.div_in;
    // a load on the same edge always wins, deferring the apply to a later boundary
    assign w_apply      = r_pending && !bus.div_load && (w_wrap || !bus.en);
    assign w_apply_idle = w_apply && !bus.en;
    assign w_div_next   = w_apply ? r_pend_val : r_div_cur;
    assign w_hi_len     = w_div_next - (w_div_next >> 1);
    clk_tick_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (bus.en),
        .i_clr      (w_apply_idle),
        .i_div      (r_div_cur),
        .o_cnt      (w_cnt),
        .o_cnt_next (w_cnt_next),
        .o_wrap     (w_wrap)
    );
    // divisor reload handshake and registered tick/clk_div outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cur  <= WIDTH'(DEFAULT_DIV);
            r_pending  <= 1'b0;
            r_pend_val <= '0;
            r_tick     <= 1'b0;
            r_clk_div  <= CLKDIV_RST;
        end else begin
            r_div_cur <= w_div_next;
            r_pending <= bus.div_load || (r_pending && !w_apply);
            if (bus.div_load) r_pend_val <= w_div_in;
            r_tick    <= w_wrap;
            if (bus.en || w_apply_idle) r_clk_div <= (w_cnt_next < w_hi_len);
        end
    end
    assign bus.pending = r_pending;
    assign bus.div_cur = r_div_cur;
    assign bus.cnt     = w_cnt;
    assign bus.tick    = r_tick;
    assign bus.clk_div = r_clk_div;
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: scoreboard bench against a period-level model of the tick generator
module tb_clk_tick_gen;
    localparam int WIDTH = 16;
    localparam int DEF   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_tick_gen_if #(.WIDTH(WIDTH)) bus ();
    clk_tick_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit pend;
        int dcur;
        int cnt;
        bit tick;
        bit cdiv;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // reference state: position within the current period, divisor, reload slot
    int m_p = 0, m_d = DEF, m_pv = 0;
    bit m_pend = 0, m_tick = 0, m_cd = 1;

    task automatic model(input bit r, input bit e, input int din, input bit ld);
        bit wrap, apply;
        if (!r) begin
            m_p = 0; m_d = DEF; m_pend = 0; m_pv = 0; m_tick = 0; m_cd = 1;
            return;
        end
        wrap  = e && (m_p == m_d - 1);
        apply = m_pend && !ld && (wrap || !e);
        if (e) begin
            m_tick = wrap;
            m_p    = wrap ? 0 : m_p + 1;
            if (apply) m_d = m_pv;
            m_cd   = m_p < (m_d + 1) / 2;
        end else begin
            m_tick = 0;
            if (apply) begin
                m_p = 0; m_d = m_pv; m_cd = 1;
            end
        end
        if (ld) begin
            m_pv = (din == 0) ? 1 : din;
            m_pend = 1;
        end else if (apply) m_pend = 0;
    endtask

    task automatic cyc(input bit r, input bit e, input int din, input bit ld);
        exp_t x;
        rst_n = r; bus.en = e; bus.div_in = WIDTH'(din); bus.div_load = ld;
        model(r, e, din, ld);
        x = '{m_pend, m_d, m_p, m_tick, m_cd};
        @(posedge clk);
        q.push_back(x);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", n, $time, a, e);
        end
    endtask

    // monitor: one expected record per clock edge, compared mid-cycle
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("pending", 32'(bus.pending), 32'(x.pend));
                chk("div_cur", 32'(bus.div_cur), x.dcur);
                chk("cnt",     32'(bus.cnt),     x.cnt);
                chk("tick",    32'(bus.tick),    32'(x.tick));
                chk("clk_div", 32'(bus.clk_div), 32'(x.cdiv));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.div_in = '0; bus.div_load = 1'b0;
        repeat (2) cyc(0, 0, 0, 0);
        repeat (14) cyc(1, 1, 0, 0);
        while (m_p != 1) cyc(1, 1, 0, 0);
        cyc(1, 1, 3, 1);
        repeat (12) cyc(1, 1, 0, 0);
        while (m_p != 2) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        repeat (6) cyc(1, 1, 0, 0);
        cyc(1, 0, 4, 1);
        cyc(1, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0);
        while (m_p != m_d - 1) cyc(1, 1, 0, 0);
        cyc(1, 1, 6, 1);
        repeat (20) cyc(1, 1, 0, 0);
        while (m_p != 0) cyc(1, 1, 0, 0);
        cyc(1, 1, 5, 1);
        cyc(1, 1, 7, 1);
        repeat (20) cyc(1, 1, 0, 0);
        while (m_p != 0) cyc(1, 1, 0, 0);
        cyc(1, 1, 3, 1);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (10) cyc(1, 1, 0, 0);
        repeat (800)
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 9)), $urandom_range(0, 7) == 0);
        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
